serial_alu_n: RTL and testbench
===============================

Name: serial_alu_n

Overview:
- Multi-cycle, parametrised N-bit ALU for the MIPS datapath.
- Iterates a DIGIT-bit slice over the operand words, LSB digit first.
- Opcode set matches the existing 1-bit ALU slice: AND, OR, ADD, SUB, SLT. Outputs carry, overflow (V), set and zero.
- Start/done handshake; used by the multi-cycle controller when area matters more than latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A, latched at accepted start
- b  in  WIDTH  operand B, latched at accepted start
- alu_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others unsupported
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result outputs valid from this cycle
- result  out  WIDTH  operation result
- carry_out  out  1  carry out of MSB (ADD/SUB/SLT), else 0
- v  out  1  signed overflow (ADD/SUB/SLT), else 0
- set  out  1  SLT flag: MSB of (a-b) XOR v; computed for SUB/SLT, else 0
- zero  out  1  result == 0

Behaviour:
- Reset (rst_n low at edge), from any state including mid-RUN:
  - State goes to IDLE; working registers are cleared.
  - busy, done, result, carry_out, v, set and zero all go to 0.
  - The aborted operation produces no done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 latches a, b, alu_op and clears the digit counter.
  - Carry-in is set to alu_op[2] (B-invert for SUB/SLT).
  - Next state is RUN.
- RUN:
  - Each edge processes digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT) into a working result register.
  - Carry ripples internally within the digit; the carry register holds the inter-digit carry.
  - B-invert applies when alu_op[2]=1.
- Final RUN edge (E0+N), k=N-1:
  - Carry into the MSB and carry out of the MSB are captured.
  - v = cin_msb XOR cout_msb.
  - set = sum_msb XOR v.
  - SLT: result = {WIDTH-1 zeros, set}.
  - Output registers are loaded; next state is DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE unconditionally.
  - start during DONE is ignored (not queued).
- Latency: done is high in the cycle following edge E0+N (N=32 for defaults; N=4 for DIGIT=8).
- Back-to-back: the earliest next accepted start is the IDLE edge after DONE, giving N+2 cycles per operation.
- start while RUN or DONE: ignored; the latched operands are unaffected.
- a, b and alu_op may change freely after the accepted start.
- Output registers hold the last completed values until the next completion. They do not change mid-RUN.
- Unsupported opcodes (011, 100, 101):
  - Same latency and done pulse.
  - result=0, carry_out=0, v=0, set=0, zero=1.
- Logic ops: carry_out=0, v=0, set=0.
- Arithmetic is modulo 2^WIDTH.
- SUB/SLT carry_out = 1 when a >= b unsigned (no borrow).
- DIGIT=WIDTH is legal: N=1, done after two edges.

Test Plan:
- WIDTH=32, DIGIT=1, ADD a=0x7FFFFFFF b=0x00000001:
  - result=0x80000000, v=1, carry_out=0, zero=0.
  - busy high for 32 cycles; done exactly 1 cycle, 32 edges after the start edge.
- SUB a=5 b=5:
  - result=0, zero=1, carry_out=1, v=0, set=0.
- SLT:
  - a=0xFFFFFFFF b=0x00000001: result=0x00000001, set=1.
  - a=0x80000000 b=0x00000001: result=1, v=1, set=1 (overflow-corrected).
  - a=3 b=2: result=0, set=0.
- WIDTH=32, DIGIT=8, a=0xF0F0F0F0 b=0xFF00FF00:
  - AND -> 0xF000F000; OR -> 0xFFF0FFF0; carry_out=0, v=0.
  - done after 4 RUN cycles.
- Handshake and reset:
  - start held high for the whole operation: exactly one operation.
  - a/b changed mid-RUN: result unaffected.
  - start pulsed during DONE: ignored.
  - rst_n low at RUN cycle 10: all outputs 0, busy=0, no done.
  - Fresh ADD 2+3 after reset -> result 5.
- alu_op=011 with a=0xFFFFFFFF b=0xFFFFFFFF:
  - result=0, zero=1, carry_out=0, v=0, set=0.
  - done at the normal latency.

Source files
------------

// File: rtl/serial_alu_n.sv
// Digit-serial N-bit ALU (AND/OR/ADD/SUB/SLT), LSB digit first, start/done handshake.
// Ports: clk, rst_n, start, a, b, alu_op in; busy, done, result, carry_out, v, set, zero out.
module serial_alu_n #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             v,
   output logic             set,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] aSh;
   logic [WIDTH-1:0] bSh;
   logic [WIDTH-1:0] accRes;
   logic [2:0]       opReg;
   logic [CW-1:0]    cnt;
   logic             carryReg;

   logic isAnd, isOr, isAdd, isSub, isSlt, isArith;

   always_comb begin
      isAnd = 1'b0;
      isOr  = 1'b0;
      isAdd = 1'b0;
      isSub = 1'b0;
      isSlt = 1'b0;
      unique case (1'b1)
         (opReg == 3'b000): isAnd = 1'b1;
         (opReg == 3'b001): isOr  = 1'b1;
         (opReg == 3'b010): isAdd = 1'b1;
         (opReg == 3'b110): isSub = 1'b1;
         (opReg == 3'b111): isSlt = 1'b1;
         default: ;
      endcase
   end

   assign isArith = isAdd | isSub | isSlt;

   // Ripple through the current digit; operands sit in bit 0 upward
   // because the shift registers move the next digit down each cycle.
   logic [DIGIT-1:0] digSum;
   logic [DIGIT-1:0] digLog;
   logic [DIGIT-1:0] digRes;
   logic             digCarry;
   logic             cinMsb;
   logic             coutMsb;
   logic             bInv;

   always_comb begin
      digSum   = '0;
      digLog   = '0;
      digCarry = carryReg;
      cinMsb   = 1'b0;
      bInv     = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         bInv      = bSh[i] ^ opReg[2];
         digSum[i] = aSh[i] ^ bInv ^ digCarry;
         cinMsb    = digCarry;
         digCarry  = (aSh[i] & bInv) | (aSh[i] & digCarry)
                   | (bInv & digCarry);
         digLog[i] = isAnd ? (aSh[i] & bSh[i]) : (aSh[i] | bSh[i]);
      end
      coutMsb = digCarry;
   end

   always_comb begin
      digRes = '0;
      unique case (1'b1)
         (isAnd | isOr): digRes = digLog;
         isArith:        digRes = digSum;
         default: ;
      endcase
   end

   // New digit enters at the top; after N cycles the word is aligned.
   logic [WIDTH-1:0] digWide;
   logic [WIDTH-1:0] nextAcc;
   logic [WIDTH-1:0] finalRes;
   logic             vNext;
   logic             setNext;

   assign digWide  = WIDTH'(digRes);
   assign nextAcc  = (accRes >> DIGIT) | (digWide << (WIDTH - DIGIT));
   assign vNext    = cinMsb ^ coutMsb;
   assign setNext  = digSum[DIGIT-1] ^ vNext;
   assign finalRes = isSlt ? WIDTH'(setNext) : nextAcc;

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         aSh       <= '0;
         bSh       <= '0;
         accRes    <= '0;
         opReg     <= '0;
         cnt       <= '0;
         carryReg  <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         v         <= 1'b0;
         set       <= 1'b0;
         zero      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  aSh      <= a;
                  bSh      <= b;
                  opReg    <= alu_op;
                  cnt      <= '0;
                  carryReg <= alu_op[2];
                  accRes   <= '0;
                  state    <= RUN;
               end
            end
            RUN: begin
               aSh      <= aSh >> DIGIT;
               bSh      <= bSh >> DIGIT;
               accRes   <= nextAcc;
               carryReg <= coutMsb;
               cnt      <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  result    <= finalRes;
                  carry_out <= isArith & coutMsb;
                  v         <= isArith & vNext;
                  set       <= (isSub | isSlt) & setNext;
                  zero      <= (finalRes == '0);
                  state     <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_alu_n.sv
// Directed self-checking bench for serial_alu_n (DIGIT=1 and DIGIT=8).
// Drives handshake, operand scrambling, start during DONE and mid-RUN reset.
module tb_serial_alu_n;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start [2];
   logic [31:0] aIn   [2];
   logic [31:0] bIn   [2];
   logic [2:0]  opIn  [2];
   logic        busy  [2];
   logic        done  [2];
   logic [31:0] res   [2];
   logic        cOut  [2];
   logic        vOut  [2];
   logic        sOut  [2];
   logic        zOut  [2];

   int nChk = 0;
   int nErr = 0;

   always #5 clk = ~clk;

   serial_alu_n #(.WIDTH(32), .DIGIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[0]),
      .a(aIn[0]), .b(bIn[0]), .alu_op(opIn[0]),
      .busy(busy[0]), .done(done[0]), .result(res[0]),
      .carry_out(cOut[0]), .v(vOut[0]), .set(sOut[0]),
      .zero(zOut[0])
   );

   serial_alu_n #(.WIDTH(32), .DIGIT(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start[1]),
      .a(aIn[1]), .b(bIn[1]), .alu_op(opIn[1]),
      .busy(busy[1]), .done(done[1]), .result(res[1]),
      .carry_out(cOut[1]), .v(vOut[1]), .set(sOut[1]),
      .zero(zOut[1])
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      nChk++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic runOp(input int s, input string tag,
                        input logic [31:0] ai, input logic [31:0] bi,
                        input logic [2:0] op, input logic [31:0] eRes,
                        input logic eC, input logic eV, input logic eS,
                        input bit hold);
      int n;
      int nBusy;
      int lat;
      logic [31:0] prev;
      lat  = (s == 1) ? 4 : 32;
      prev = res[s];
      @(negedge clk);
      aIn[s]   = ai;
      bIn[s]   = bi;
      opIn[s]  = op;
      start[s] = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start[s] = 1'b0;
      aIn[s]  = ~ai;
      bIn[s]  = 32'h1234_5678;
      opIn[s] = 3'b001;
      n     = 0;
      nBusy = 0;
      while (!done[s] && n < 200) begin
         if (busy[s]) nBusy++;
         if (n == lat / 2) chk({tag, "/holdMid"}, 64'(res[s]), 64'(prev));
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "/latency"}, 64'(n), 64'(lat));
      chk({tag, "/busyCycles"}, 64'(nBusy), 64'(lat));
      chk({tag, "/busyAtDone"}, 64'(busy[s]), 64'd0);
      chk({tag, "/result"}, 64'(res[s]), 64'(eRes));
      chk({tag, "/carry"}, 64'(cOut[s]), 64'(eC));
      chk({tag, "/v"}, 64'(vOut[s]), 64'(eV));
      chk({tag, "/set"}, 64'(sOut[s]), 64'(eS));
      chk({tag, "/zero"}, 64'(zOut[s]), 64'(eRes == 32'd0));
      start[s] = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "/donePulse"}, 64'(done[s]), 64'd0);
      chk({tag, "/startInDone"}, 64'(busy[s]), 64'd0);
      start[s] = 1'b0;
   endtask

   initial begin
      int doneSeen;
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         start[s] = 1'b0;
         aIn[s]   = '0;
         bIn[s]   = '0;
         opIn[s]  = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("rst/busy", 64'(busy[s]), 64'd0);
         chk("rst/done", 64'(done[s]), 64'd0);
         chk("rst/result", 64'(res[s]), 64'd0);
         chk("rst/carry", 64'(cOut[s]), 64'd0);
         chk("rst/v", 64'(vOut[s]), 64'd0);
         chk("rst/set", 64'(sOut[s]), 64'd0);
         chk("rst/zero", 64'(zOut[s]), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      runOp(0, "addOvf", 32'h7FFF_FFFF, 32'h0000_0001, 3'b010,
            32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      runOp(0, "subEq", 32'd5, 32'd5, 3'b110,
            32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      runOp(0, "subNeg", 32'd2, 32'd3, 3'b110,
            32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
      runOp(0, "sltM1", 32'hFFFF_FFFF, 32'h0000_0001, 3'b111,
            32'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      runOp(0, "sltOvf", 32'h8000_0000, 32'h0000_0001, 3'b111,
            32'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      runOp(0, "slt32", 32'd3, 32'd2, 3'b111,
            32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      runOp(0, "op011", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011,
            32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      runOp(0, "orHold", 32'h0F0F_0000, 32'h0000_00F0, 3'b001,
            32'h0F0F_00F0, 1'b0, 1'b0, 1'b0, 1'b1);
      runOp(0, "addHold", 32'd1, 32'd1, 3'b010,
            32'd2, 1'b0, 1'b0, 1'b0, 1'b1);

      runOp(1, "and8", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000,
            32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
      runOp(1, "or8", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001,
            32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
      runOp(1, "addWrap8", 32'hFFFF_FFFF, 32'h0000_0001, 3'b010,
            32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      runOp(1, "sltOvf8", 32'h8000_0000, 32'h0000_0001, 3'b111,
            32'd1, 1'b1, 1'b1, 1'b1, 1'b0);

      @(negedge clk);
      aIn[0]   = 32'h1111_1111;
      bIn[0]   = 32'h2222_2222;
      opIn[0]  = 3'b010;
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midRst/busy", 64'(busy[0]), 64'd0);
      chk("midRst/done", 64'(done[0]), 64'd0);
      chk("midRst/result", 64'(res[0]), 64'd0);
      chk("midRst/carry", 64'(cOut[0]), 64'd0);
      chk("midRst/v", 64'(vOut[0]), 64'd0);
      chk("midRst/set", 64'(sOut[0]), 64'd0);
      chk("midRst/zero", 64'(zOut[0]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      doneSeen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done[0] || busy[0]) doneSeen++;
      end
      chk("midRst/noDone", 64'(doneSeen), 64'd0);

      runOp(0, "addFresh", 32'd2, 32'd3, 3'b010,
            32'd5, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", nChk, nErr);
      $finish;
   end

endmodule
